// File: rtl/ssp_dmem_responder.sv
// rtl/ssp_dmem_responder.sv - word-addressed load/store responder with latency pipeline and in-order response queue (optional SSP_DMEM_ERRCHK_EN)
module ssp_dmem_responder #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024,
    parameter int LAT    = 2,
    parameter int QDEPTH = 4
) (
    input  logic        clk1,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_tag,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [2:0]  rsp_tag,
    output logic        rsp_err,
    output logic        busy
);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);

    // Storage array; name kept as MEM so benches can preload it hierarchically.
    logic [31:0] MEM [0:DEPTH-1];

    logic [ADDR_W-1:0] idx;
    logic              err;
    logic              accept;
    logic              pop;
    logic              push;

    // Latency pipeline: stage 0 is the read capture, LAT-1 shift stages follow.
    logic [LAT-1:0]    pv;
    logic [LAT-1:0]    pe;
    logic [31:0]       pd [0:LAT-1];
    logic [2:0]        pt [0:LAT-1];

    // Response queue.
    logic [31:0]       qd [0:QDEPTH-1];
    logic [2:0]        qt [0:QDEPTH-1];
    logic [QDEPTH-1:0] qe;
    logic [PW-1:0]     wp;
    logic [PW-1:0]     rp;
    logic [CW-1:0]     qcnt;

    // Outstanding count covers both pipeline and queue, so the queue cannot overflow.
    logic [CW-1:0]     ocnt;
    logic [CW-1:0]     ocnt_next;
    logic              rdy_q;

`ifdef SSP_DMEM_ERRCHK_EN
    assign err = (req_addr >= 32'(DEPTH));
    assign idx = req_addr[ADDR_W-1:0];
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:ADDR_W];
    assign err = 1'b0;
    assign idx = ADDR_W'({{(32-ADDR_W){1'b0}}, req_addr[ADDR_W-1:0]} % 32'(DEPTH));
`endif

    assign req_ready = rdy_q;
    assign accept    = req_valid && rdy_q;
    assign rsp_valid = (qcnt != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign push      = pv[LAT-1];
    assign rsp_rdata = rsp_valid ? qd[rp] : 32'd0;
    assign rsp_tag   = rsp_valid ? qt[rp] : 3'd0;
    assign rsp_err   = rsp_valid && qe[rp];
    assign busy      = (ocnt != '0);

    // Next outstanding count: accept adds one, pop removes one, both cancel.
    always_comb begin
        ocnt_next = ocnt;
        if (accept && !pop) begin
            ocnt_next = ocnt + CW'(1);
        end else if (pop && !accept) begin
            ocnt_next = ocnt - CW'(1);
        end
    end

    // Datapath: memory access at acceptance, pipeline shift, queue write (no reset needed, valid bits gate it).
    always_ff @(posedge clk1) begin
        if (accept && req_we && !err) begin
            MEM[idx] <= req_wdata;
        end
        if (accept) begin
            pd[0] <= (req_we || err) ? 32'd0 : MEM[idx];
            pt[0] <= req_tag;
            pe[0] <= err;
        end
        for (int i = 1; i < LAT; i++) begin
            pd[i] <= pd[i-1];
            pt[i] <= pt[i-1];
            pe[i] <= pe[i-1];
        end
        if (push) begin
            qd[wp] <= pd[LAT-1];
            qt[wp] <= pt[LAT-1];
            qe[wp] <= pe[LAT-1];
        end
    end

    // Control: pipeline valids, queue pointers/count, outstanding count and registered ready.
    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            pv    <= '0;
            wp    <= '0;
            rp    <= '0;
            qcnt  <= '0;
            ocnt  <= '0;
            rdy_q <= 1'b0;
        end else begin
            pv[0] <= accept;
            for (int i = 1; i < LAT; i++) begin
                pv[i] <= pv[i-1];
            end
            if (push) begin
                wp <= (wp == PW'(QDEPTH - 1)) ? '0 : wp + PW'(1);
            end
            if (pop) begin
                rp <= (rp == PW'(QDEPTH - 1)) ? '0 : rp + PW'(1);
            end
            if (push && !pop) begin
                qcnt <= qcnt + CW'(1);
            end else if (pop && !push) begin
                qcnt <= qcnt - CW'(1);
            end
            ocnt  <= ocnt_next;
            rdy_q <= (ocnt_next < CW'(QDEPTH));
        end
    end
endmodule

// File: tb/tb_ssp_dmem_responder.sv
// tb/tb_ssp_dmem_responder.sv - self-checking bench for ssp_dmem_responder
module tb_ssp_dmem_responder;
    localparam int LAT = 2;
    localparam int QD  = 4;
`ifdef SSP_DMEM_ERRCHK_EN
    localparam bit ERRCHK = 1'b1;
`else
    localparam bit ERRCHK = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  tag;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [2:0]  tag;
        logic        err;
    } rsp_t;

    logic        clk1 = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_tag;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [2:0]  rsp_tag;
    logic        rsp_err;
    logic        busy;

    int          n_vec = 0;
    int          n_bad = 0;
    logic        last_acc;
    logic [31:0] ref_mem [0:1023];
    rsp_t        exp_q [$];
    vec_t        tbl [8];

    ssp_dmem_responder dut (
        .clk1      (clk1),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_tag   (req_tag),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_tag   (rsp_tag),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk1 = ~clk1;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endfunction

    // Reference: a flat memory and a FIFO of expected responses in acceptance order.
    function automatic void model_accept();
        rsp_t        r;
        int unsigned i;
        logic        e;
        e = ERRCHK && (req_addr >= 32'd1024);
        i = req_addr % 1024;
        r.tag = req_tag;
        r.err = e;
        r.rdata = 32'd0;
        if (req_we) begin
            if (!e) ref_mem[i] = req_wdata;
        end else if (!e) begin
            r.rdata = ref_mem[i];
        end
        exp_q.push_back(r);
    endfunction

    task automatic cycle();
        logic        acc;
        logic        stalled;
        logic [31:0] hd;
        logic [2:0]  ht;
        logic        he;
        rsp_t        e;
        acc     = req_valid && req_ready;
        stalled = rsp_valid && !rsp_ready;
        hd = rsp_rdata;
        ht = rsp_tag;
        he = rsp_err;
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL spurious_rsp: got tag %0d want no response", rsp_tag);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
        if (acc) model_accept();
        last_acc = acc;
        @(posedge clk1);
        #1;
        if (stalled) begin
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rdata", rsp_rdata, hd);
            chk("hold_tag", 32'(rsp_tag), 32'(ht));
            chk("hold_err", 32'(rsp_err), 32'(he));
        end
        chk("busy", 32'(busy), 32'(exp_q.size() != 0));
        chk("req_ready", 32'(req_ready), 32'(exp_q.size() < QD));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        int k;
        int sent;
        int nxt;
        int acc_cnt;
        reset = 1'b0;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_addr = 32'd0;
        req_wdata = 32'd0;
        req_tag = 3'd0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'(i) * 32'd3 + 32'd7;
        for (int i = 1; i <= 5; i++) ref_mem[i] = 32'(i);
        ref_mem[6]  = 32'd66;
        ref_mem[50] = 32'd100;
        for (int i = 0; i < 1024; i++) dut.MEM[i] = ref_mem[i];

        tbl[0] = '{1'b0, 32'd50,   32'd0,          3'd1, 32'd100,                          1'b0};
        tbl[1] = '{1'b1, 32'd1030, 32'd7,          3'd4, 32'd0,                            ERRCHK};
        tbl[2] = '{1'b0, 32'd1030, 32'd0,          3'd5, ERRCHK ? 32'd0 : 32'd7,           ERRCHK};
        tbl[3] = '{1'b0, 32'd6,    32'd0,          3'd6, ERRCHK ? 32'd66 : 32'd7,          1'b0};
        tbl[4] = '{1'b1, 32'd1023, 32'h12345678,   3'd7, 32'd0,                            1'b0};
        tbl[5] = '{1'b0, 32'd1023, 32'd0,          3'd0, 32'h12345678,                     1'b0};
        tbl[6] = '{1'b0, 32'd2047, 32'd0,          3'd2, ERRCHK ? 32'd0 : 32'h12345678,    ERRCHK};
        tbl[7] = '{1'b0, 32'd5,    32'd0,          3'd3, 32'd5,                            1'b0};

        #3;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk1);
        #1;
        reset = 1'b1;
        @(posedge clk1);
        #1;
        chk("ready_after_reset", 32'(req_ready), 32'd1);

        // Single requests with exact latency and table-fixed results.
        rsp_ready = 1'b1;
        foreach (tbl[v]) begin
            req_valid = 1'b1;
            req_we    = tbl[v].we;
            req_addr  = tbl[v].addr;
            req_wdata = tbl[v].wdata;
            req_tag   = tbl[v].tag;
            cycle();
            chk("tbl_accept", 32'(last_acc), 32'd1);
            req_valid = 1'b0;
            k = 0;
            while (!rsp_valid && k < 20) begin
                cycle();
                k++;
            end
            chk("tbl_latency", 32'(k), 32'(LAT));
            chk("tbl_rdata", rsp_rdata, tbl[v].exp_rdata);
            chk("tbl_tag", 32'(rsp_tag), 32'(tbl[v].tag));
            chk("tbl_err", 32'(rsp_err), 32'(tbl[v].exp_err));
            cycle();
        end
        chk("mem6", dut.MEM[6], ERRCHK ? 32'd66 : 32'd7);

        // Back-to-back store then load to the same word.
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'd60;
        req_wdata = 32'hDEADBEEF;
        req_tag   = 3'd2;
        cycle();
        req_we  = 1'b0;
        req_tag = 3'd3;
        cycle();
        req_valid = 1'b0;
        cycle();
        chk("b2b_v0", 32'(rsp_valid), 32'd1);
        chk("b2b_tag0", 32'(rsp_tag), 32'd2);
        chk("b2b_rdata0", rsp_rdata, 32'd0);
        cycle();
        chk("b2b_v1", 32'(rsp_valid), 32'd1);
        chk("b2b_tag1", 32'(rsp_tag), 32'd3);
        chk("b2b_rdata1", rsp_rdata, 32'hDEADBEEF);
        cycle();
        chk("b2b_idle", 32'(rsp_valid), 32'd0);

        // Credit exhaustion: five loads offered against a stalled response channel.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        acc_cnt   = 0;
        nxt       = 1;
        for (int c = 0; c < 10; c++) begin
            req_addr = 32'(nxt);
            req_tag  = nxt[2:0];
            cycle();
            if (last_acc) begin
                acc_cnt++;
                nxt++;
            end
        end
        chk("bp_accepted", 32'(acc_cnt), 32'd4);
        chk("bp_ready_low", 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        for (int c = 0; c < 20 && nxt < 6; c++) begin
            req_addr = 32'(nxt);
            req_tag  = nxt[2:0];
            cycle();
            if (last_acc) nxt++;
        end
        req_valid = 1'b0;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) cycle();
        chk("bp_fifth", 32'(nxt), 32'd6);
        chk("bp_drain_busy", 32'(busy), 32'd0);
        chk("bp_drain_valid", 32'(rsp_valid), 32'd0);

        // Three-load burst with rsp_ready toggling every cycle.
        sent = 0;
        for (int c = 0; c < 40; c++) begin
            if (sent == 3 && exp_q.size() == 0) break;
            req_valid = (sent < 3);
            req_addr  = 32'd10 + 32'(sent);
            req_tag   = 3'(sent + 4);
            rsp_ready = c[0];
            cycle();
            if (last_acc) sent++;
        end
        req_valid = 1'b0;
        chk("burst_sent", 32'(sent), 32'd3);
        chk("burst_busy", 32'(busy), 32'd0);

        // Randomised traffic; addresses 0..15 or their aliases at 1024..1039.
        for (int c = 0; c < 400; c++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_we    = $urandom_range(0, 1) == 1;
            req_addr  = 32'($urandom_range(0, 15)) + (($urandom_range(0, 3) == 0) ? 32'd1024 : 32'd0);
            req_wdata = $urandom;
            req_tag   = 3'($urandom_range(0, 7));
            rsp_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 30 && exp_q.size() > 0; c++) cycle();
        chk("rand_drained", 32'(busy), 32'd0);

        // Reset with three loads in flight.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        sent = 0;
        for (int c = 0; c < 10 && sent < 3; c++) begin
            req_addr = 32'd20 + 32'(sent);
            req_tag  = 3'(sent);
            cycle();
            if (last_acc) sent++;
        end
        req_valid = 1'b0;
        chk("mid_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #2;
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        #2;
        reset = 1'b1;
        rsp_ready = 1'b1;
        cycle();
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        for (int c = 0; c < 6; c++) begin
            cycle();
            chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        req_valid = 1'b1;
        req_addr  = 32'd60;
        req_tag   = 3'd5;
        cycle();
        req_valid = 1'b0;
        k = 0;
        while (!rsp_valid && k < 20) begin
            cycle();
            k++;
        end
        chk("post_rst_latency", 32'(k), 32'(LAT));
        chk("post_rst_mem60", rsp_rdata, 32'hDEADBEEF);
        chk("post_rst_tag", 32'(rsp_tag), 32'd5);
        cycle();
        chk("final_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/ssp_dmem_responder.md
Name: ssp_dmem_responder

Overview:
- Word-addressed data-memory responder. It services load/store requests issued by the superscalar processor's load/store unit.
- Single request channel and single in-order response channel, both with valid/ready handshakes.
- Read latency is parameterised; a response queue with credit-based backpressure decouples the two channels.
- The storage array is named MEM so benches preload it hierarchically, as is done for the processor's MEM.

Parameters:
- ADDR_W, 10: word-index width used to address MEM.
- DEPTH, 1024: number of 32-bit words in MEM (must be ≤ 2^ADDR_W).
- LAT, 2: cycles from request acceptance to earliest rsp_valid (≥1).
- QDEPTH, 4: maximum outstanding requests (pipeline plus response queue).

Ports:
- clk1  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store (SW), 0 = load (LW).
- req_addr  in  32  word address (effective address from the LSU).
- req_wdata  in  32  store data.
- req_tag  in  3  LSU tag, echoed on the response.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  LSU accepts the response.
- rsp_rdata  out  32  load data; 0 for store acks.
- rsp_tag  out  3  echoed tag.
- rsp_err  out  1  address error flag.
- busy  out  1  at least one request outstanding.

Behaviour:
- Clock and reset: one clock (clk1); reset is asynchronous and active-low.
- Reset values:
  - rsp_valid=0, rsp_rdata=0, rsp_tag=0, rsp_err=0, busy=0, req_ready=0 while reset is low.
  - Pipeline and response queue are emptied; the outstanding count is 0.
  - MEM contents are not reset.
- Acceptance: a request is accepted on a rising edge when req_valid && req_ready.
- req_ready is 1 out of reset when outstanding < QDEPTH. It is driven from registered state only and has no same-cycle dependence on rsp_ready.
- Index: idx = req_addr[ADDR_W-1:0].
- Store: MEM[idx] is written at the acceptance edge. An ack (rdata=0, err=0) enters the pipeline.
- Load: MEM[idx] is read at the acceptance edge, so the access order equals the acceptance order. A load accepted after a store to the same address returns the new data.
- Latency:
  - Data and tag pass through a LAT-1 stage valid-tagged shift pipeline, then into the response queue (QDEPTH entries, FIFO).
  - A request accepted at edge N gives rsp_valid=1 after edge N+LAT, provided the queue was empty.
  - Full throughput of one request per cycle when rsp_ready=1.
- Response channel:
  - Responses are strictly in order.
  - rsp_valid/rsp_rdata/rsp_tag/rsp_err are held stable while rsp_valid && !rsp_ready.
  - The head is popped on rsp_valid && rsp_ready.
- Outstanding counter:
  - +1 on accept, −1 on pop; unchanged on a simultaneous accept and pop.
  - It never exceeds QDEPTH, so the queue cannot overflow.
  - busy = (outstanding != 0).
- Reset mid-operation: in-flight responses are discarded, no response is emitted for them, and stores already written remain in MEM.
- rsp_tag is a pure echo; tags are not checked for uniqueness.

Optional Feature:
- Macro: SSP_DMEM_ERRCHK_EN.
- Defined:
  - req_addr >= DEPTH gives rsp_err=1 and rsp_rdata=0.
  - A store to such an address does not write MEM.
  - The error response keeps its normal position in response order.
- Undefined:
  - The address wraps (idx = req_addr[ADDR_W-1:0] mod DEPTH).
  - rsp_err is tied to 0.

Test Plan:
1. Preload MEM[50]=100; LW addr 50, tag 1, rsp_ready=1 → rsp_valid exactly 2 cycles after acceptance, rsp_rdata=100, rsp_tag=1, rsp_err=0.
2. SW addr 60 data 32'hDEADBEEF (tag 2), then LW addr 60 (tag 3) back-to-back → ack with tag 2 and rdata=0, then tag 3 with rdata=32'hDEADBEEF, in consecutive cycles.
3. rsp_ready=0 while 5 LWs are offered (addrs 1..5, MEM[i]=i) → 4 accepted and req_ready falls after the 4th. Raise rsp_ready → rdata 1,2,3,4 in order, then the 5th is accepted and returns 5.
4. Backpressure hold: rsp_ready toggled 0/1 every cycle during a 3-load burst → outputs stable while stalled, no duplicated or lost tag, busy falls after the last pop.
5. With SSP_DMEM_ERRCHK_EN: SW addr 1030 data 7, then LW addr 1030 → both responses have rsp_err=1 and MEM[6] is unchanged. Without the macro → MEM[6]=7 and the load returns 7 with rsp_err=0.
6. Assert reset (low) with 3 loads outstanding → rsp_valid=0 immediately. After release: req_ready=1, busy=0, no stale responses, and an earlier store to addr 60 is still readable.
